// File: rtl/rtl_settings_pkg.sv
// Shared types and constants for the memory-test control path.
package rtl_settings_pkg;

  typedef enum logic [1:0] {
    WRITE_READ = 2'd0,
    WRITE_ONLY = 2'd1,
    READ_ONLY  = 2'd2,
    MARCH      = 2'd3
  } test_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLaunch,
    StRun,
    StGap,
    StDone
  } sched_state_t;

  // Position of the test-mode field inside test_param[1].
  localparam int unsigned TEST_MODE_MSB = 15;
  localparam int unsigned TEST_MODE_LSB = 14;

endpackage

// File: rtl/test_scheduler_watchdog.sv
// Loadable down-counter; expired strobes on the enabled cycle that consumes the last count.
// A load value of 0 never expires.
module sched_watchdog #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: load has priority over counting, stops at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired = en && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/test_scheduler.sv
// Multi-pass test campaign sequencer driving control_block and collecting results.
module test_scheduler
  import rtl_settings_pkg::*;
#(
  parameter int unsigned PASS_CNT_W = 8,
  parameter int unsigned GAP_W      = 8,
  parameter int unsigned TIMEOUT_W  = 24,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sched_start_i,
  input  logic                  sched_abort_i,
  input  logic [PASS_CNT_W-1:0] pass_num_i,
  input  logic [1:0]            step_num_i,
  input  logic [3:0][1:0]       step_mode_i,
  input  logic [2:1][31:0]      base_param_i,
  input  logic                  stop_on_err_i,
  input  logic [GAP_W-1:0]      gap_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  output logic                  start_test_o,
  output logic [2:1][31:0]      test_param_o,
  input  logic                  test_finished_i,
  input  logic                  test_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic [PASS_CNT_W-1:0] fail_pass_o,
  output logic [1:0]            fail_step_o
);

  // One counter serves both the RUN watchdog and the GAP delay.
  localparam int unsigned WdW = (TIMEOUT_W > GAP_W) ? TIMEOUT_W : GAP_W;

  sched_state_t state_q, state_d;

  // Configuration captured at campaign start.
  logic [PASS_CNT_W-1:0] pass_num_q;
  logic [1:0]            step_num_q;
  logic [3:0][1:0]       step_mode_q;
  logic [2:1][31:0]      base_q;
  logic                  stop_q;
  logic [GAP_W-1:0]      gap_q;
  logic [TIMEOUT_W-1:0]  timeout_q;

  logic [PASS_CNT_W-1:0] pass_q, pass_d;
  logic [1:0]            step_q, step_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [2:1][31:0]      param_q, param_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q_flag, timeout_d_flag;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [PASS_CNT_W-1:0] fail_pass_q, fail_pass_d;
  logic [1:0]            fail_step_q, fail_step_d;

  logic           take_start;
  logic           last_test;
  logic           wd_load, wd_en, wd_expired;
  logic [WdW-1:0] wd_load_val;

  assign take_start = (state_q == StIdle) && sched_start_i;
  assign last_test  = (step_q == step_num_q) && (pass_q == pass_num_q - PASS_CNT_W'(1));
  assign wd_en      = (state_q == StRun) || (state_q == StGap);

  sched_watchdog #(
    .WIDTH (WdW)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (wd_load),
    .load_val (wd_load_val),
    .en       (wd_en),
    .expired  (wd_expired)
  );

  // Next-state, result bookkeeping and counter control.
  always_comb begin
    state_d        = state_q;
    pass_d         = pass_q;
    step_d         = step_q;
    abort_pend_d   = abort_pend_q;
    param_d        = param_q;
    fail_d         = fail_q;
    timeout_d_flag = timeout_q_flag;
    err_cnt_d      = err_cnt_q;
    fail_pass_d    = fail_pass_q;
    fail_step_d    = fail_step_q;
    wd_load        = 1'b0;
    wd_load_val    = '0;

    case (state_q)
      StIdle: begin
        // Abort is ignored here, including when it coincides with start.
        if (sched_start_i) begin
          state_d        = (pass_num_i == '0) ? StDone : StSetup;
          pass_d         = '0;
          step_d         = '0;
          abort_pend_d   = 1'b0;
          fail_d         = 1'b0;
          timeout_d_flag = 1'b0;
          err_cnt_d      = '0;
          fail_pass_d    = '0;
          fail_step_d    = '0;
        end
      end
      StSetup: begin
        param_d = base_q;
        param_d[1][TEST_MODE_MSB:TEST_MODE_LSB] = step_mode_q[step_q];
        state_d = sched_abort_i ? StDone : StLaunch;
      end
      StLaunch: begin
        wd_load     = 1'b1;
        wd_load_val = WdW'(timeout_q);
        if (sched_abort_i) abort_pend_d = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (sched_abort_i) abort_pend_d = 1'b1;
        // Finish beats a same-cycle watchdog expiry.
        if (test_finished_i) begin
          if (test_result_i) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
              fail_pass_d = pass_q;
              fail_step_d = step_q;
            end
            fail_d = 1'b1;
          end
          if ((test_result_i && stop_q) || abort_pend_q || sched_abort_i || last_test) begin
            state_d = StDone;
          end else begin
            if (step_q == step_num_q) begin
              step_d = '0;
              pass_d = pass_q + 1'b1;
            end else begin
              step_d = step_q + 2'd1;
            end
            if (gap_q != '0) begin
              wd_load     = 1'b1;
              wd_load_val = WdW'(gap_q);
              state_d     = StGap;
            end else begin
              state_d = StSetup;
            end
          end
        end else if (wd_expired) begin
          timeout_d_flag = 1'b1;
          fail_d         = 1'b1;
          state_d        = StDone;
        end
      end
      StGap: begin
        if (sched_abort_i) begin
          state_d = StDone;
        end else if (wd_expired) begin
          state_d = StSetup;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      pass_q         <= '0;
      step_q         <= '0;
      abort_pend_q   <= 1'b0;
      param_q        <= '0;
      fail_q         <= 1'b0;
      timeout_q_flag <= 1'b0;
      err_cnt_q      <= '0;
      fail_pass_q    <= '0;
      fail_step_q    <= '0;
    end else begin
      state_q        <= state_d;
      pass_q         <= pass_d;
      step_q         <= step_d;
      abort_pend_q   <= abort_pend_d;
      param_q        <= param_d;
      fail_q         <= fail_d;
      timeout_q_flag <= timeout_d_flag;
      err_cnt_q      <= err_cnt_d;
      fail_pass_q    <= fail_pass_d;
      fail_step_q    <= fail_step_d;
    end
  end

  // Configuration snapshot taken when a campaign is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_num_q  <= '0;
      step_num_q  <= '0;
      step_mode_q <= '0;
      base_q      <= '0;
      stop_q      <= 1'b0;
      gap_q       <= '0;
      timeout_q   <= '0;
    end else if (take_start) begin
      pass_num_q  <= pass_num_i;
      step_num_q  <= step_num_i;
      step_mode_q <= step_mode_i;
      base_q      <= base_param_i;
      stop_q      <= stop_on_err_i;
      gap_q       <= gap_i;
      timeout_q   <= timeout_i;
    end
  end

  assign start_test_o = (state_q == StLaunch);
  assign done_o       = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign test_param_o = param_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q_flag;
  assign err_cnt_o    = err_cnt_q;
  assign fail_pass_o  = fail_pass_q;
  assign fail_step_o  = fail_step_q;

endmodule

// File: tb/tb_test_scheduler.sv
// Randomized and directed campaigns against a behavioural model of the scheduler.
module tb_test_scheduler;
  import rtl_settings_pkg::*;

  localparam int unsigned PassW = 8;
  localparam int unsigned GapW  = 8;
  localparam int unsigned ToW   = 24;
  localparam int unsigned ErrW  = 2;
  localparam int ErrMax = 3;
  localparam int Budget = 3000;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             sched_start_i, sched_abort_i;
  logic [PassW-1:0] pass_num_i;
  logic [1:0]       step_num_i;
  logic [3:0][1:0]  step_mode_i;
  logic [2:1][31:0] base_param_i;
  logic             stop_on_err_i;
  logic [GapW-1:0]  gap_i;
  logic [ToW-1:0]   timeout_i;
  logic             start_test_o;
  logic [2:1][31:0] test_param_o;
  logic             test_finished_i, test_result_i;
  logic             busy_o, done_o, fail_o, timeout_o;
  logic [ErrW-1:0]  err_cnt_o;
  logic [PassW-1:0] fail_pass_o;
  logic [1:0]       fail_step_o;

  int n_checks = 0;
  int n_errors = 0;
  bit res_tbl[32];
  logic [3:0][1:0] m;

  always #5 clk = ~clk;

  test_scheduler #(
    .PASS_CNT_W (PassW),
    .GAP_W      (GapW),
    .TIMEOUT_W  (ToW),
    .ERR_CNT_W  (ErrW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .sched_start_i   (sched_start_i),
    .sched_abort_i   (sched_abort_i),
    .pass_num_i      (pass_num_i),
    .step_num_i      (step_num_i),
    .step_mode_i     (step_mode_i),
    .base_param_i    (base_param_i),
    .stop_on_err_i   (stop_on_err_i),
    .gap_i           (gap_i),
    .timeout_i       (timeout_i),
    .start_test_o    (start_test_o),
    .test_param_o    (test_param_o),
    .test_finished_i (test_finished_i),
    .test_result_i   (test_result_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .fail_o          (fail_o),
    .timeout_o       (timeout_o),
    .err_cnt_o       (err_cnt_o),
    .fail_pass_o     (fail_pass_o),
    .fail_step_o     (fail_step_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // abort_mode: 0 none, 1 abort in first gap cycle, 2 abort during first RUN, 3 abort with start.
  task automatic run_campaign(input string tag, input int pnum, input int snum,
                              input logic [3:0][1:0] modes, input bit stop, input int gap,
                              input int tmo, input int lat, input int hang_idx,
                              input int abort_mode, input int extra_start);
    int exp_modes[$];
    int exp_n, exp_err, exp_fp, exp_fs, exp_done;
    bit exp_fail, exp_to, ended;
    int t, rem, n_start, n_done, done_t, first_fin, last_fin, start_t, hang_t;
    logic [2:1][31:0] base, want;

    // Reference model: walk the test list in order and apply the campaign rules.
    exp_n = 0; exp_err = 0; exp_fp = 0; exp_fs = 0; exp_fail = 0; exp_to = 0; ended = 0;
    for (int p = 0; p < pnum && !ended; p++) begin
      for (int s = 0; s <= snum && !ended; s++) begin
        exp_modes.push_back(int'(modes[s]));
        if (exp_n == hang_idx) begin
          exp_to = 1; exp_fail = 1; ended = 1;
        end else begin
          if (res_tbl[exp_n]) begin
            if (exp_err == 0) begin exp_fp = p; exp_fs = s; end
            if (exp_err < ErrMax) exp_err++;
            exp_fail = 1;
            if (stop) ended = 1;
          end
          if (abort_mode == 1 || abort_mode == 2) ended = 1;
        end
        exp_n++;
      end
    end

    base = {$urandom, $urandom};
    pass_num_i    = PassW'(pnum);
    step_num_i    = 2'(snum);
    step_mode_i   = modes;
    base_param_i  = base;
    stop_on_err_i = stop;
    gap_i         = GapW'(gap);
    timeout_i     = ToW'(tmo);
    sched_start_i = 1'b1;
    sched_abort_i = (abort_mode == 3);

    rem = 0; n_start = 0; n_done = 0; done_t = -1; first_fin = -1; last_fin = -1;
    start_t = -1; hang_t = -1; t = 0;
    while (t < Budget && !(n_done > 0 && t >= done_t + 3)) begin
      @(negedge clk);
      t++;
      sched_start_i = 1'b0; sched_abort_i = 1'b0;
      test_finished_i = 1'b0; test_result_i = 1'b0;
      if (start_test_o) begin
        if (n_start == 0) check({tag, " start latency"}, 64'(t), 64'd2);
        else check({tag, " finish-to-start"}, 64'(t - last_fin), 64'(gap + 2));
        want = base;
        if (n_start < exp_modes.size()) want[1][15:14] = 2'(exp_modes[n_start]);
        check({tag, " test_param"}, test_param_o, want);
        if (n_start == hang_idx) begin hang_t = t; rem = -1; end
        else rem = lat;
        start_t = t;
        n_start++;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          test_finished_i = 1'b1;
          test_result_i   = res_tbl[n_start-1];
          if (first_fin < 0) first_fin = t;
          last_fin = t;
        end
      end
      if (done_o) begin
        n_done++;
        done_t = t;
        check({tag, " busy at done"}, busy_o, 1);
      end
      if (abort_mode == 1 && first_fin >= 0 && t == first_fin + 1) sched_abort_i = 1'b1;
      if (abort_mode == 2 && n_start == 1 && t == start_t + 2) sched_abort_i = 1'b1;
      if (extra_start > 0 && t == extra_start && n_done == 0) sched_start_i = 1'b1;
    end

    if (n_done == 0) check({tag, " done within budget"}, 0, 1);
    check({tag, " starts"}, 64'(n_start), 64'(exp_n));
    check({tag, " done pulses"}, 64'(n_done), 64'd1);
    if (pnum == 0) begin
      check({tag, " done window"}, 64'(done_t >= 1 && done_t <= 2), 64'd1);
    end else begin
      if (exp_to) exp_done = hang_t + tmo + 1;
      else if (abort_mode == 1) exp_done = first_fin + 2;
      else exp_done = last_fin + 1;
      check({tag, " done time"}, 64'(done_t), 64'(exp_done));
    end
    check({tag, " err_cnt"}, err_cnt_o, 64'(exp_err));
    check({tag, " fail"}, fail_o, exp_fail);
    check({tag, " timeout"}, timeout_o, exp_to);
    check({tag, " fail_pass"}, fail_pass_o, 64'(exp_fp));
    check({tag, " fail_step"}, fail_step_o, 64'(exp_fs));
    check({tag, " busy after"}, busy_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    sched_start_i = 0; sched_abort_i = 0; pass_num_i = '0; step_num_i = '0;
    step_mode_i = '0; base_param_i = '0; stop_on_err_i = 0; gap_i = '0; timeout_i = '0;
    test_finished_i = 0; test_result_i = 0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset start", start_test_o, 0);
    check("reset fail", fail_o, 0);
    check("reset timeout", timeout_o, 0);
    check("reset err_cnt", err_cnt_o, 0);
    check("reset fail_pass", fail_pass_o, 0);
    check("reset fail_step", fail_step_o, 0);
    check("reset test_param", test_param_o, 0);

    m = '0;
    m[0] = WRITE_ONLY;
    m[1] = READ_ONLY;
    for (int i = 0; i < 32; i++) res_tbl[i] = 0;
    run_campaign("plan_wr", 2, 1, m, 0, 3, 0, 10, -1, 0, 0);
    res_tbl[1] = 1;
    run_campaign("fail_nostop", 3, 0, m, 0, 2, 0, 10, -1, 0, 0);
    run_campaign("fail_stop", 3, 0, m, 1, 2, 0, 10, -1, 0, 0);
    res_tbl[1] = 0;
    run_campaign("timeout", 2, 0, m, 0, 0, 50, 10, 0, 0, 0);
    run_campaign("pass0", 0, 1, m, 0, 0, 0, 10, -1, 0, 0);
    run_campaign("abort_gap", 3, 0, m, 0, 3, 0, 10, -1, 1, 0);
    run_campaign("abort_run", 3, 0, m, 0, 3, 0, 10, -1, 2, 0);
    run_campaign("abort_start", 2, 0, m, 0, 1, 0, 5, -1, 3, 0);
    run_campaign("fin_eq_to", 1, 0, m, 0, 0, 10, 10, -1, 0, 0);
    for (int i = 0; i < 32; i++) res_tbl[i] = 1;
    run_campaign("err_sat", 5, 0, m, 0, 1, 0, 4, -1, 0, 0);

    for (int k = 0; k < 25; k++) begin
      int pn, sn, gp, to, lt, hi, total, xs;
      bit st;
      pn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      sn = $urandom_range(0, 3);
      st = 1'($urandom_range(0, 1));
      gp = $urandom_range(0, 4);
      lt = $urandom_range(1, 12);
      xs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 40));
      for (int i = 0; i < 4; i++) m[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < 32; i++) res_tbl[i] = ($urandom_range(0, 3) == 0);
      total = pn * (sn + 1);
      hi = -1;
      case ($urandom_range(0, 3))
        0: to = 0;
        1: to = lt;
        2: to = lt + int'($urandom_range(1, 20));
        default: begin
          to = lt + int'($urandom_range(0, 20));
          if (total > 0) hi = $urandom_range(0, total - 1);
        end
      endcase
      run_campaign($sformatf("rnd%0d", k), pn, sn, m, st, gp, to, lt, hi, 0, xs);
    end

    // Reset in the middle of a campaign clears everything.
    pass_num_i = 8'd3; step_num_i = 2'd0; gap_i = '0; timeout_i = '0; stop_on_err_i = 0;
    sched_start_i = 1'b1;
    @(negedge clk);
    sched_start_i = 1'b0;
    for (int i = 0; i < 10 && !start_test_o; i++) @(negedge clk);
    @(negedge clk);
    test_finished_i = 1'b1; test_result_i = 1'b1;
    @(negedge clk);
    test_finished_i = 1'b0; test_result_i = 1'b0;
    check("mid fail set", fail_o, 1);
    check("mid busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid reset busy", busy_o, 0);
    check("mid reset fail", fail_o, 0);
    check("mid reset err_cnt", err_cnt_o, 0);
    check("mid reset param", test_param_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
